key_search_ctrl: RTL and testbench

//  Brute-force RC4 key search controller, directly upstream of arcfour.
//  - Drives key/start_sig into arcfour and waits for arcfour_finished.
//  - Reads back the decrypted-message RAM and accepts the key only if every byte is 'a'..'z' or space.
//  - On reject, advances the key and relaunches arcfour until a key passes or the range is exhausted.

---
 rtl/key_search_pkg.sv | 25 ++
 rtl/key_search_ctrl_msg_byte_checker.sv | 28 ++
 rtl/key_search_ctrl.sv | 141 ++++++++++++++
 tb/tb_key_search_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_pkg.sv
// Shared types and helpers for the RC4 brute-force key search controller.
package key_search_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_RC4,
      S_RD,
      S_CHK,
      S_NEXT,
      S_GAP,
      S_DONE_OK,
      S_DONE_FAIL
   } ksc_state_t;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_A     = 8'h61;
   localparam logic [7:0] CHAR_Z     = 8'h7A;

   // A plaintext byte is acceptable if it is a lowercase letter or a space.
   function automatic logic is_msg_char(input logic [7:0] b);
      return (b == CHAR_SPACE) || ((b >= CHAR_A) && (b <= CHAR_Z));
   endfunction

endpackage

// File: rtl/key_search_ctrl_msg_byte_checker.sv
// Per-byte plaintext check plus a running AND of every byte seen for the
// current key. clear re-arms the accumulator before each key's readback.
module msg_byte_checker
   import key_search_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] rdata,
   output logic       byte_ok,
   output logic       all_valid,
   output logic       acc_ok
);

   assign byte_ok = is_msg_char(rdata);
   // acc_ok already includes the byte being checked this cycle
   assign acc_ok  = all_valid & byte_ok;

   // Accumulate validity of all bytes read for the current key
   always_ff @(posedge clk) begin
      if (reset || clear)
         all_valid <= 1'b1;
      else if (en)
         all_valid <= all_valid & byte_ok;
   end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key search controller sitting in front of arcfour.
// Build option: KSC_EARLY_ABORT_EN -- reject a key on its first bad byte
// instead of reading the whole message.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start, nothing found yet
// S_LAUNCH    | rc4_start raised for the current key
// S_WAIT_RC4  | rc4_start held until arcfour_finished
// S_RD        | dec_addr presented to decrypted RAM
// S_CHK       | dec_rdata checked against the plaintext alphabet
// S_NEXT      | key rejected; advance or give up at KEY_LAST
// S_GAP       | one idle cycle so arcfour sees rc4_start low before relaunch
// S_DONE_OK   | key accepted and frozen, found=1
// S_DONE_FAIL | range exhausted, exhausted=1
module key_search_ctrl
   import key_search_pkg::*;
#(
   parameter int               KEY_W     = 24,
   parameter int               MSG_LEN   = 32,
   parameter int               ADDR_W    = 5,
   parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
   parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              arcfour_finished,
   output logic              rc4_start,
   output logic [KEY_W-1:0]  key,
   output logic [ADDR_W-1:0] dec_addr,
   input  logic [7:0]        dec_rdata,
   output logic              busy,
   output logic              found,
   output logic              exhausted
);

   ksc_state_t        state, state_nxt;
   logic [KEY_W-1:0]  key_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              chk_clear, chk_en;
   logic              byte_ok, all_valid, acc_ok;
   logic              last_byte;

   assign last_byte = (dec_addr == ADDR_W'(MSG_LEN - 1));

   msg_byte_checker u_checker (
      .clk       (clk),
      .reset     (reset),
      .clear     (chk_clear),
      .en        (chk_en),
      .rdata     (dec_rdata),
      .byte_ok   (byte_ok),
      .all_valid (all_valid),
      .acc_ok    (acc_ok)
   );

   // State, key and read-address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         key      <= KEY_FIRST;
         dec_addr <= '0;
      end else begin
         state    <= state_nxt;
         key      <= key_nxt;
         dec_addr <= addr_nxt;
      end
   end

   // Next-state, key advance and address sequencing
   always_comb begin
      state_nxt = state;
      key_nxt   = key;
      addr_nxt  = dec_addr;
      chk_clear = 1'b0;
      chk_en    = 1'b0;
      case (state)
         S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
            if (start) begin
               state_nxt = S_LAUNCH;
               key_nxt   = KEY_FIRST;
            end
         end
         S_LAUNCH:
            state_nxt = S_WAIT_RC4;
         S_WAIT_RC4: begin
            if (arcfour_finished) begin
               state_nxt = S_RD;
               addr_nxt  = '0;
               chk_clear = 1'b1;
            end
         end
         S_RD:
            state_nxt = S_CHK;
         S_CHK: begin
            chk_en = 1'b1;
`ifdef KSC_EARLY_ABORT_EN
            if (!byte_ok)
               state_nxt = S_NEXT;
            else if (last_byte)
               state_nxt = acc_ok ? S_DONE_OK : S_NEXT;
            else begin
               state_nxt = S_RD;
               addr_nxt  = dec_addr + ADDR_W'(1);
            end
`else
            // Always read the full message; decide only on the last byte.
            if (last_byte)
               state_nxt = acc_ok ? S_DONE_OK : S_NEXT;
            else begin
               state_nxt = S_RD;
               addr_nxt  = dec_addr + ADDR_W'(1);
            end
`endif
         end
         S_NEXT: begin
            // KEY_LAST is tested before incrementing, so the key never wraps.
            if (key == KEY_LAST)
               state_nxt = S_DONE_FAIL;
            else begin
               state_nxt = S_GAP;
               key_nxt   = key + KEY_W'(1);
            end
         end
         S_GAP:
            state_nxt = S_LAUNCH;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded directly from the state register
   always_comb begin
      rc4_start = (state == S_LAUNCH) || (state == S_WAIT_RC4);
      busy      = !((state == S_IDLE) || (state == S_DONE_OK) || (state == S_DONE_FAIL));
      found     = (state == S_DONE_OK);
      exhausted = (state == S_DONE_FAIL);
   end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: stub arcfour (finished 20 clk after rc4_start
// rises), 1-clk-latency decrypted RAM, and a key/message table model.
// Instance 0 searches from key 0; instance 1 starts at 3FFFFE with no valid key.
module tb_key_search_ctrl;

`ifdef KSC_EARLY_ABORT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int MSG_LEN = 32;

   logic        clk = 1'b0;
   logic [1:0]  reset, start, fin, spur, rc4_start, busy, found, exhausted;
   logic [23:0] key   [2];
   logic [4:0]  addr  [2];
   logic [7:0]  rdata [2];

   int checks = 0;
   int errors = 0;

   logic [7:0] tbl [16][MSG_LEN];
   int         first_bad [16];
   int         cnt [2] = '{0, 0};
   int         launches [2] = '{0, 0};
   int         low_cnt [2] = '{0, 0};
   int         gap_log [2][64];
   bit         prev [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   key_search_ctrl u_dut0 (
      .clk(clk), .reset(reset[0]), .start(start[0]), .arcfour_finished(fin[0]),
      .rc4_start(rc4_start[0]), .key(key[0]), .dec_addr(addr[0]), .dec_rdata(rdata[0]),
      .busy(busy[0]), .found(found[0]), .exhausted(exhausted[0])
   );

   key_search_ctrl #(.KEY_FIRST(24'h3FFFFE)) u_dut1 (
      .clk(clk), .reset(reset[1]), .start(start[1]), .arcfour_finished(fin[1]),
      .rc4_start(rc4_start[1]), .key(key[1]), .dec_addr(addr[1]), .dec_rdata(rdata[1]),
      .busy(busy[1]), .found(found[1]), .exhausted(exhausted[1])
   );

   function automatic logic [7:0] msg_of(input int i, input logic [23:0] k, input logic [4:0] a);
      if (i == 0) return tbl[k[3:0]][a];
      return 8'h41;
   endfunction

   // Stub arcfour and RAM models
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rc4_start[i] !== 1'b1) cnt[i] <= 0;
         else if (cnt[i] < 100) cnt[i] <= cnt[i] + 1;
         rdata[i] <= msg_of(i, key[i], addr[i]);
      end
   end

   assign fin[0] = (rc4_start[0] && (cnt[0] >= 20)) || spur[0];
   assign fin[1] = (rc4_start[1] && (cnt[1] >= 20)) || spur[1];

   // Launch counter and rc4_start low-gap length preceding each launch
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rc4_start[i] === 1'b1 && !prev[i]) begin
            if (launches[i] < 64) gap_log[i][launches[i]] <= low_cnt[i];
            launches[i] <= launches[i] + 1;
            low_cnt[i]  <= 0;
         end else if (rc4_start[i] === 1'b0) begin
            low_cnt[i] <= low_cnt[i] + 1;
         end
         prev[i] <= (rc4_start[i] === 1'b1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rand_valid();
      case ($urandom_range(0, 3))
         0:       return 8'h20;
         1:       return 8'h61;
         2:       return 8'h7A;
         default: return 8'(8'h61 + $urandom_range(0, 25));
      endcase
   endfunction

   function automatic logic [7:0] rand_invalid();
      logic [7:0] bad [8];
      bad = '{8'h60, 8'h7B, 8'h1F, 8'h00, 8'hFF, 8'h41, 8'h5A, 8'h21};
      return bad[$urandom_range(0, 7)];
   endfunction

   // Keys below target get one invalid byte at a random position; target is all valid.
   task automatic build_random(input int target);
      for (int k = 0; k < 16; k++) begin
         first_bad[k] = MSG_LEN;
         for (int a = 0; a < MSG_LEN; a++) tbl[k][a] = rand_valid();
         if (k < target) begin
            first_bad[k] = $urandom_range(0, MSG_LEN - 1);
            tbl[k][first_bad[k]] = rand_invalid();
         end
      end
   endtask

   task automatic pulse_start(input int i);
      @(negedge clk); start[i] = 1'b1;
      @(negedge clk); start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      bit ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (found[i] === 1'b1 || exhausted[i] === 1'b1) begin ok = 1'b1; break; end
      end
      check("done_timeout", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   function automatic int exp_gap(input int p);
      return EARLY ? (4 + 2 * p) : (4 + 2 * (MSG_LEN - 1));
   endfunction

   // Run a search on instance 0 expecting key 'target' to be accepted.
   task automatic run_trial(input int target);
      int base;
      base = launches[0];
      pulse_start(0);
      repeat (30) @(negedge clk);
      check("busy_mid", 32'(busy[0]), 32'd1);
      start[0] = 1'b1;                       // ignored while busy
      @(negedge clk); start[0] = 1'b0;
      wait_done(0, 6000);
      check("found", 32'(found[0]), 32'd1);
      check("exhausted_lo", 32'(exhausted[0]), 32'd0);
      check("busy_done", 32'(busy[0]), 32'd0);
      check("rc4_lo_done", 32'(rc4_start[0]), 32'd0);
      check("key_found", 32'(key[0]), 32'(target));
      check("launches", 32'(launches[0] - base), 32'(target + 1));
      for (int n = 0; n < target; n++)
         check("gap", 32'(gap_log[0][base + n + 1]), 32'(exp_gap(first_bad[n])));
   endtask

   initial begin
      int base;
      reset = 2'b11; start = 2'b11; spur = 2'b00;
      for (int k = 0; k < 16; k++)
         for (int a = 0; a < MSG_LEN; a++) tbl[k][a] = 8'h61;

      // Reset held with start high: stays at reset values, never launches
      repeat (5) begin
         @(negedge clk);
         check("rst_rc4", 32'(rc4_start), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         check("rst_key", 32'(key[i]), i == 0 ? 32'h000000 : 32'h3FFFFE);
         check("rst_addr", 32'(addr[i]), 32'd0);
         check("rst_busy", 32'(busy[i]), 32'd0);
         check("rst_found", 32'(found[i]), 32'd0);
         check("rst_exh", 32'(exhausted[i]), 32'd0);
      end
      reset = 2'b00; start = 2'b00;
      @(negedge clk);
      check("rst_launches", 32'(launches[0] + launches[1]), 32'd0);

      // Only key 3 is all 'a'; keys 0..2 fail at byte 0 with the boundary rejects
      for (int k = 0; k < 16; k++) begin
         first_bad[k] = MSG_LEN;
         for (int a = 0; a < MSG_LEN; a++) tbl[k][a] = 8'h61;
      end
      tbl[0][0] = 8'h60; tbl[1][0] = 8'h7B; tbl[2][0] = 8'h1F;
      for (int k = 0; k < 3; k++) first_bad[k] = 0;
      for (int k = 4; k < 16; k++) tbl[k][5] = 8'h41;
      run_trial(3);

      // Boundary accepts 20/61/7A; key 0 fails only on its last byte (restart from DONE_OK)
      for (int a = 0; a < MSG_LEN; a++) begin
         tbl[0][a] = (a % 3 == 0) ? 8'h20 : ((a % 3 == 1) ? 8'h61 : 8'h7A);
         tbl[1][a] = (a % 3 == 0) ? 8'h7A : ((a % 3 == 1) ? 8'h20 : 8'h61);
      end
      tbl[0][MSG_LEN-1] = 8'h7B;
      first_bad[0] = MSG_LEN - 1;
      run_trial(1);

      // Randomized tables against the first-valid-key model
      repeat (3) begin
         int t;
         t = $urandom_range(1, 6);
         build_random(t);
         run_trial(t);
      end

      // Reset 3 clk into WAIT_RC4 of the third key
      build_random(5);
      base = launches[0];
      pulse_start(0);
      for (int c = 0; c < 2000 && launches[0] < base + 3; c++) @(negedge clk);
      check("reach_launch3", 32'(launches[0] >= base + 3), 32'd1);
      check("key_before_rst", 32'(key[0]), 32'd2);
      repeat (3) @(negedge clk);
      reset[0] = 1'b1;
      @(posedge clk); #1;
      check("abort_rc4", 32'(rc4_start[0]), 32'd0);
      check("abort_key", 32'(key[0]), 32'd0);
      check("abort_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      reset[0] = 1'b0; spur[0] = 1'b1;
      repeat (5) @(negedge clk);
      spur[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("spur_rc4", 32'(rc4_start[0]), 32'd0);
      check("spur_busy", 32'(busy[0]), 32'd0);
      check("spur_found", 32'(found[0]), 32'd0);

      // Instance 1: two-key range with no valid key
      pulse_start(1);
      wait_done(1, 2000);
      check("exh_flag", 32'(exhausted[1]), 32'd1);
      check("exh_found", 32'(found[1]), 32'd0);
      check("exh_key", 32'(key[1]), 32'h3FFFFF);
      check("exh_busy", 32'(busy[1]), 32'd0);
      check("exh_launches", 32'(launches[1]), 32'd2);
      check("exh_gap", 32'(gap_log[1][1]), 32'(exp_gap(0)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
